// File: rtl/instr_fetch_unit.sv
// Fetch stage: latches the PC, reads instruction memory, and holds the word for the decoder.
// Optional fetch timeout with a sticky error state when IFETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_e;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;
`endif

    // A zero timeout would underflow the terminal-count compare.
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                valid_q, valid_d;
    logic                inc_q, inc_d;

`ifdef IFETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        inc_d   = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        addr_d  = pc_in;
                        state_d = FETCH;
`ifdef IFETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                FETCH: begin
                    if (mem_rdy) begin
                        ir_d    = mem_data;
                        valid_d = 1'b1;
                        inc_d   = 1'b1;
                        state_d = HOLD;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
`endif
                end
                HOLD: begin
                    if (valid_q && ir_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            inc_q   <= inc_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_rd   = (state_q == FETCH);
    assign mem_addr = addr_q;
    assign ir_out   = ir_q;
    assign ir_valid = valid_q;
    assign pc_inc   = inc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and memory environment, output-level reference model,
// per-cycle comparison plus directed literal checks. Timeout cases need IFETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

    localparam int unsigned TCYC = 8;

    logic        clk = 1'b0;
    logic        rst, run, flush, mem_rdy, ir_ready;
    logic [15:0] pc_q = 16'h0000;
    logic [15:0] mem_data, mem_addr, ir_out;
    logic        pc_inc, mem_rd, ir_valid, fetch_err;

    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        use_fixed;
    logic [15:0] fixed_data;

    int n_err    = 0;
    int n_checks = 0;
    int inc_cnt  = 0;
    int inc0;

    // Reference model: expected output values
    logic [15:0] e_addr  = '0;
    logic [15:0] e_ir    = '0;
    logic        e_rd    = 1'b0;
    logic        e_valid = 1'b0;
    logic        e_inc   = 1'b0;
    logic        e_err   = 1'b0;
    int          e_waits = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .flush    (flush),
        .pc_in    (pc_q),
        .pc_inc   (pc_inc),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data),
        .ir_out   (ir_out),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .fetch_err(fetch_err)
    );

    // PC register environment: branch load wins over increment
    always @(posedge clk) begin
        if (pc_load)     pc_q <= pc_load_val;
        else if (pc_inc) pc_q <= pc_q + 16'h0001;
    end

    assign mem_data = use_fixed ? fixed_data : (mem_addr ^ 16'h5A00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Model: a fetch is outstanding while a read is expected, an instruction is
    // held while valid is expected; otherwise the unit is idle.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                e_addr = '0; e_ir = '0; e_rd = 1'b0; e_valid = 1'b0;
                e_inc = 1'b0; e_err = 1'b0; e_waits = 0;
            end else if (flush) begin
                e_rd = 1'b0; e_valid = 1'b0; e_inc = 1'b0; e_err = 1'b0;
            end else begin
                e_inc = 1'b0;
                if (e_err) begin
                end else if (e_valid) begin
                    if (ir_ready) e_valid = 1'b0;
                end else if (e_rd) begin
                    if (mem_rdy) begin
                        e_ir = mem_data; e_valid = 1'b1; e_inc = 1'b1; e_rd = 1'b0;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (e_waits + 1 >= int'(TCYC)) begin
                        e_err = 1'b1; e_rd = 1'b0;
                    end
`endif
                    else e_waits++;
                end else if (run) begin
                    e_addr = pc_q; e_rd = 1'b1; e_waits = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (pc_inc === 1'b1) inc_cnt++;
            chk("cyc_mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("cyc_mem_rd",    32'(mem_rd),    32'(e_rd));
            chk("cyc_ir_out",    32'(ir_out),    32'(e_ir));
            chk("cyc_ir_valid",  32'(ir_valid),  32'(e_valid));
            chk("cyc_pc_inc",    32'(pc_inc),    32'(e_inc));
            chk("cyc_fetch_err", 32'(fetch_err), 32'(e_err));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(mem_addr),  32'h0);
        chk({tag, "_rd"},    32'(mem_rd),    32'h0);
        chk({tag, "_ir"},    32'(ir_out),    32'h0);
        chk({tag, "_valid"}, 32'(ir_valid),  32'h0);
        chk({tag, "_inc"},   32'(pc_inc),    32'h0);
        chk({tag, "_err"},   32'(fetch_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; flush = 1'b0; mem_rdy = 1'b0; ir_ready = 1'b0;
        pc_load = 1'b1; pc_load_val = 16'h0010; use_fixed = 1'b1; fixed_data = 16'hA5C3;
        tick(2);
        chk_all_zero("reset");

        // Single fetch, zero-wait memory, decoder ready
        rst = 1'b0; pc_load = 1'b0; run = 1'b1; mem_rdy = 1'b1; ir_ready = 1'b1;
        inc0 = inc_cnt;
        tick(1);
        chk("t1_addr", 32'(mem_addr), 32'h0010);
        chk("t1_rd",   32'(mem_rd),   32'h1);
        tick(1);
        chk("t1_ir",    32'(ir_out),   32'hA5C3);
        chk("t1_valid", 32'(ir_valid), 32'h1);
        chk("t1_inc",   32'(pc_inc),   32'h1);
        use_fixed = 1'b0;
        tick(1);
        chk("t1_valid_drop", 32'(ir_valid), 32'h0);
        chk("t1_inc_pulse",  32'(pc_inc),   32'h0);
        chk("t1_one_inc",    32'(inc_cnt - inc0), 32'h1);

        // Back-to-back: one instruction every 3 cycles at consecutive addresses
        tick(1);
        chk("t2_addr1", 32'(mem_addr), 32'h0011);
        tick(1);
        chk("t2_ir1", 32'(ir_out), 32'h5A11);
        tick(2);
        chk("t2_addr2", 32'(mem_addr), 32'h0012);
        tick(1);
        chk("t2_ir2", 32'(ir_out), 32'h5A12);
        run = 1'b0;
        tick(2);
        chk("t2_parked", 32'(mem_rd), 32'h0);
        chk("t2_incs",   32'(inc_cnt - inc0), 32'h3);

        // Decoder stalls for 5 cycles after capture
        run = 1'b1; ir_ready = 1'b0; inc0 = inc_cnt;
        tick(1);
        chk("t3_addr", 32'(mem_addr), 32'h0013);
        tick(1);
        chk("t3_valid", 32'(ir_valid), 32'h1);
        repeat (5) begin
            tick(1);
            chk("t3_hold_valid", 32'(ir_valid), 32'h1);
            chk("t3_hold_ir",    32'(ir_out),   32'h5A13);
            chk("t3_no_rd",      32'(mem_rd),   32'h0);
        end
        run = 1'b0; ir_ready = 1'b1;
        tick(1);
        chk("t3_accept",  32'(ir_valid), 32'h0);
        chk("t3_one_inc", 32'(inc_cnt - inc0), 32'h1);

        // Flush coincident with mem_rdy, branch to 0x0200
        run = 1'b1; mem_rdy = 1'b0; inc0 = inc_cnt;
        tick(1);
        chk("t4_addr", 32'(mem_addr), 32'h0014);
        flush = 1'b1; mem_rdy = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0200;
        tick(1);
        chk("t4_valid", 32'(ir_valid), 32'h0);
        chk("t4_inc",   32'(pc_inc),   32'h0);
        chk("t4_rd",    32'(mem_rd),   32'h0);
        flush = 1'b0; pc_load = 1'b0;
        tick(1);
        chk("t4_branch_addr", 32'(mem_addr), 32'h0200);
        tick(1);
        chk("t4_ir",     32'(ir_out),  32'h5800);
        chk("t4_incs",   32'(inc_cnt - inc0), 32'h1);
        run = 1'b0;
        tick(1);

        // Reset in FETCH, then in HOLD
        run = 1'b1; mem_rdy = 1'b0;
        tick(1);
        chk("t6_fetch_rd", 32'(mem_rd), 32'h1);
        rst = 1'b1;
        tick(1);
        chk_all_zero("t6_rst_fetch");
        rst = 1'b0; mem_rdy = 1'b1; ir_ready = 1'b0;
        tick(2);
        chk("t6_hold_valid", 32'(ir_valid), 32'h1);
        rst = 1'b1;
        tick(1);
        chk_all_zero("t6_rst_hold");
        rst = 1'b0; run = 1'b0; ir_ready = 1'b1;
        tick(1);

`ifdef IFETCH_TIMEOUT_EN
        // Memory never answers: error after TCYC fetch cycles, cleared by flush
        run = 1'b1; mem_rdy = 1'b0;
        tick(1);
        chk("t5_rd_start", 32'(mem_rd), 32'h1);
        tick(TCYC - 1);
        chk("t5_err_before", 32'(fetch_err), 32'h0);
        chk("t5_rd_before",  32'(mem_rd),    32'h1);
        tick(1);
        chk("t5_err_set", 32'(fetch_err), 32'h1);
        chk("t5_rd_off",  32'(mem_rd),    32'h0);
        tick(3);
        chk("t5_err_sticky", 32'(fetch_err), 32'h1);
        chk("t5_rd_stays",   32'(mem_rd),    32'h0);
        flush = 1'b1;
        tick(1);
        chk("t5_err_clr", 32'(fetch_err), 32'h0);
        flush = 1'b0; mem_rdy = 1'b1;
        tick(1);
        chk("t5_resume_rd", 32'(mem_rd), 32'h1);
        tick(1);
        chk("t5_resume_valid", 32'(ir_valid), 32'h1);
`else
        // Without the timeout a long memory stall just waits
        run = 1'b1; mem_rdy = 1'b0;
        tick(20);
        chk("nt_rd_wait", 32'(mem_rd),    32'h1);
        chk("nt_no_err",  32'(fetch_err), 32'h0);
        mem_rdy = 1'b1;
        tick(1);
        chk("nt_valid", 32'(ir_valid), 32'h1);
`endif
        run = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
